// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle main control FSM (fetch/decode/execute/memory/writeback)
//   clk, rst_n (async, active-low)
//   opcode, zero, mem_ready           -> IR opcode field, ALU zero flag, memory done
//   mem_req, mem_we, adr_src          -> unified memory request, write strobe, address select
//   ir_write, pc_write, reg_write     -> IR/OldPC load, PC load, regfile write
//   alu_src_a, alu_src_b, alu_op      -> ALU operand selects and operation class
//   result_src                        -> result bus select
//   illegal                           -> pulse in DECODE on an unsupported opcode
//   state_o                           -> current state, zero-extended to STATE_W
module multicycle_control #(
  parameter int SUPPORT_JAL = 1,
  parameter int SUPPORT_LUI = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         result_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_LUI    = 4'd11;
  localparam logic JAL_EN = SUPPORT_JAL != 0;
  localparam logic LUI_EN = SUPPORT_LUI != 0;
  logic [3:0] state, state_n, dec_n;
  logic       legal;
  always_comb begin
    dec_n = S_FETCH;
    legal = 1'b1;
    case (opcode)
      7'b0000011, 7'b0100011: dec_n = S_MEMADR;
      7'b0110011: dec_n = S_EXECR;
      7'b0010011: dec_n = S_EXECI;
      7'b1100011: dec_n = S_BEQ;
      7'b1101111: begin
        dec_n = JAL_EN ? S_JAL : S_FETCH;
        legal = JAL_EN;
      end
      7'b0110111: begin
        dec_n = LUI_EN ? S_LUI : S_FETCH;
        legal = LUI_EN;
      end
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_n    = S_FETCH;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_n    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = ~legal;
        state_n   = dec_n;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_n   = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_n = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        state_n = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_n   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_n   = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_n   = S_ALUWB;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      default: state_n = S_FETCH;
    endcase
    // Hold everything quiet while reset is low so no enable leaks out mid-instruction.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      illegal    = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_FETCH;
    else state <= state_n;
  assign state_o = STATE_W'(state);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table, directed corner cases and random checks of multicycle_control
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic a_req, a_we, a_adr, a_ir, a_pc, a_rw, a_ill;
  logic [1:0] a_asa, a_asb, a_aop, a_rs;
  logic [3:0] a_st;
  logic b_req, b_we, b_adr, b_ir, b_pc, b_rw, b_ill;
  logic [1:0] b_asa, b_asb, b_aop, b_rs;
  logic [5:0] b_st;
  logic [14:0] a_o, b_o;
  int checks = 0;
  int errors = 0;
  assign a_o = {a_req, a_we, a_adr, a_ir, a_pc, a_rw, a_asa, a_asb, a_aop, a_rs, a_ill};
  assign b_o = {b_req, b_we, b_adr, b_ir, b_pc, b_rw, b_asa, b_asb, b_aop, b_rs, b_ill};
  always #5 clk = ~clk;
  multicycle_control dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_req), .mem_we(a_we), .adr_src(a_adr), .ir_write(a_ir), .pc_write(a_pc),
    .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop),
    .result_src(a_rs), .illegal(a_ill), .state_o(a_st)
  );
  multicycle_control #(.SUPPORT_JAL(0), .SUPPORT_LUI(0), .STATE_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_req), .mem_we(b_we), .adr_src(b_adr), .ir_write(b_ir), .pc_write(b_pc),
    .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop),
    .result_src(b_rs), .illegal(b_ill), .state_o(b_st)
  );
  // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, asa, asb, aop, rs, illegal}
  localparam logic [14:0] F1 = 15'b1_0_0_1_1_0_00_10_00_10_0;
  localparam logic [14:0] F0 = 15'b1_0_0_0_0_0_00_10_00_10_0;
  localparam logic [14:0] DC = 15'b0_0_0_0_0_0_01_01_00_00_0;
  localparam logic [14:0] DI = 15'b0_0_0_0_0_0_01_01_00_00_1;
  localparam logic [14:0] MA = 15'b0_0_0_0_0_0_10_01_00_00_0;
  localparam logic [14:0] MR = 15'b1_0_1_0_0_0_00_00_00_00_0;
  localparam logic [14:0] MB = 15'b0_0_0_0_0_1_00_00_00_01_0;
  localparam logic [14:0] MW = 15'b1_1_1_0_0_0_00_00_00_00_0;
  localparam logic [14:0] ER = 15'b0_0_0_0_0_0_10_00_10_00_0;
  localparam logic [14:0] EI = 15'b0_0_0_0_0_0_10_01_10_00_0;
  localparam logic [14:0] WB = 15'b0_0_0_0_0_1_00_00_00_00_0;
  localparam logic [14:0] B1 = 15'b0_0_0_0_1_0_10_00_01_00_0;
  localparam logic [14:0] B0 = 15'b0_0_0_0_0_0_10_00_01_00_0;
  localparam logic [14:0] JL = 15'b0_0_0_0_1_0_01_10_00_00_0;
  localparam logic [14:0] LU = 15'b0_0_0_0_0_1_00_00_00_11_0;
  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        mr;
    int          st;
    logic [14:0] o;
  } vec_t;
  vec_t vt[19];
  int pth[$];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic [6:0] op, input logic z, input logic mr, input int st,
                     input logic [14:0] o, input bit use_b, input string nm);
    @(negedge clk);
    opcode = op;
    zero = z;
    mem_ready = mr;
    #1;
    chk({nm, " state"}, use_b ? int'(b_st) : int'(a_st), st);
    chk({nm, " outs"}, use_b ? int'(b_o) : int'(a_o), int'(o));
  endtask
  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h37};
  endfunction
  function automatic logic [14:0] exp_o(input int st, input logic [6:0] op, input logic z, input logic mr);
    case (st)
      0: return mr ? F1 : F0;
      1: return is_legal(op) ? DC : DI;
      2: return MA;
      3: return MR;
      4: return MB;
      5: return MW;
      6: return ER;
      7: return EI;
      8: return WB;
      9: return z ? B1 : B0;
      10: return JL;
      11: return LU;
      default: return 15'd0;
    endcase
  endfunction
  task automatic mkpath(input logic [6:0] op);
    case (op)
      7'h03: pth = {0, 1, 2, 3, 4};
      7'h23: pth = {0, 1, 2, 5};
      7'h33: pth = {0, 1, 6, 8};
      7'h13: pth = {0, 1, 7, 8};
      7'h63: pth = {0, 1, 9};
      7'h6f: pth = {0, 1, 10, 8};
      7'h37: pth = {0, 1, 11};
      default: pth = {0, 1};
    endcase
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    logic [6:0] opl[8];
    logic [6:0] op;
    logic mr, z;
    int st, n, r;
    bit stall;
    opl = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h37, 7'h7f};
    vt[0]  = '{7'h33, 1'b0, 1'b1, 0, F1};
    vt[1]  = '{7'h33, 1'b0, 1'b1, 1, DC};
    vt[2]  = '{7'h33, 1'b0, 1'b0, 6, ER};
    vt[3]  = '{7'h33, 1'b0, 1'b0, 8, WB};
    vt[4]  = '{7'h37, 1'b0, 1'b0, 0, F0};
    vt[5]  = '{7'h37, 1'b0, 1'b1, 0, F1};
    vt[6]  = '{7'h37, 1'b0, 1'b1, 1, DC};
    vt[7]  = '{7'h37, 1'b0, 1'b1, 11, LU};
    vt[8]  = '{7'h63, 1'b1, 1'b1, 0, F1};
    vt[9]  = '{7'h63, 1'b1, 1'b1, 1, DC};
    vt[10] = '{7'h63, 1'b1, 1'b0, 9, B1};
    vt[11] = '{7'h63, 1'b0, 1'b1, 0, F1};
    vt[12] = '{7'h63, 1'b0, 1'b1, 1, DC};
    vt[13] = '{7'h63, 1'b0, 1'b1, 9, B0};
    vt[14] = '{7'h23, 1'b0, 1'b1, 0, F1};
    vt[15] = '{7'h23, 1'b0, 1'b1, 1, DC};
    vt[16] = '{7'h23, 1'b0, 1'b1, 2, MA};
    vt[17] = '{7'h23, 1'b0, 1'b0, 5, MW};
    vt[18] = '{7'h23, 1'b0, 1'b1, 5, MW};
    repeat (3) @(negedge clk);
    #1;
    chk("reset a state", int'(a_st), 0);
    chk("reset a outs", int'(a_o), 0);
    chk("reset b state", int'(b_st), 0);
    chk("reset b outs", int'(b_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vt[i]) cyc(vt[i].op, vt[i].z, vt[i].mr, vt[i].st, vt[i].o, 1'b0, $sformatf("vec%0d", i));
    cyc(7'h33, 1'b0, 1'b0, 0, F0, 1'b0, "sw done");
    cyc(7'h03, 1'b0, 1'b1, 0, F1, 1'b0, "lw fetch");
    cyc(7'h03, 1'b0, 1'b1, 1, DC, 1'b0, "lw decode");
    cyc(7'h03, 1'b0, 1'b0, 2, MA, 1'b0, "lw memadr");
    cyc(7'h03, 1'b0, 1'b0, 3, MR, 1'b0, "lw stall1");
    cyc(7'h03, 1'b0, 1'b0, 3, MR, 1'b0, "lw stall2");
    cyc(7'h03, 1'b0, 1'b0, 3, MR, 1'b0, "lw stall3");
    cyc(7'h03, 1'b0, 1'b1, 3, MR, 1'b0, "lw ready");
    cyc(7'h03, 1'b0, 1'b0, 4, MB, 1'b0, "lw memwb");
    cyc(7'h6f, 1'b0, 1'b0, 0, F0, 1'b0, "lw done");
    cyc(7'h6f, 1'b0, 1'b1, 0, F1, 1'b0, "jal fetch");
    cyc(7'h6f, 1'b0, 1'b1, 1, DC, 1'b0, "jal decode");
    cyc(7'h6f, 1'b0, 1'b0, 10, JL, 1'b0, "jal jal");
    cyc(7'h6f, 1'b0, 1'b0, 8, WB, 1'b0, "jal aluwb");
    cyc(7'h6f, 1'b0, 1'b0, 0, F0, 1'b0, "jal done");
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 8);
      op = (r == 8) ? 7'($urandom) : opl[r];
      mkpath(op);
      foreach (pth[i]) begin
        st = pth[i];
        n = 0;
        do begin
          mr = ($urandom_range(0, 2) != 0) || (n > 6);
          z = 1'($urandom);
          cyc(op, z, mr, st, exp_o(st, op, z, mr), 1'b0, $sformatf("rnd op%0h st%0d", op, st));
          stall = (st == 0 || st == 3 || st == 5) && !mr;
          n++;
        end while (stall);
      end
    end
    cyc(7'h23, 1'b0, 1'b1, 0, F1, 1'b0, "rst fetch");
    cyc(7'h23, 1'b0, 1'b1, 1, DC, 1'b0, "rst decode");
    cyc(7'h23, 1'b0, 1'b1, 2, MA, 1'b0, "rst memadr");
    cyc(7'h23, 1'b0, 1'b0, 5, MW, 1'b0, "rst memwr");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst state", int'(a_st), 0);
    chk("async rst outs", int'(a_o), 0);
    chk("async rst b outs", int'(b_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(7'h6f, 1'b0, 1'b1, 0, F1, 1'b1, "b jal fetch");
    cyc(7'h6f, 1'b0, 1'b1, 1, DI, 1'b1, "b jal illegal");
    cyc(7'h37, 1'b0, 1'b0, 0, F0, 1'b1, "b jal trap");
    cyc(7'h37, 1'b0, 1'b1, 0, F1, 1'b1, "b lui fetch");
    cyc(7'h37, 1'b0, 1'b1, 1, DI, 1'b1, "b lui illegal");
    cyc(7'h33, 1'b0, 1'b1, 0, F1, 1'b1, "b r fetch");
    cyc(7'h33, 1'b0, 1'b1, 1, DC, 1'b1, "b r decode");
    cyc(7'h33, 1'b0, 1'b0, 6, ER, 1'b1, "b r execr");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the RV32I core; successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over shared ALU and unified memory.
- Adds a memory ready handshake, JAL/LUI/I-ALU support selected by parameters, illegal-opcode trap and stall-safe sequencing.
- Sits between instruction register opcode field and datapath muxes/enables.

Parameters:
- SUPPORT_JAL, 1, 1 enables JAL decode; 0 treats 1101111 as illegal.
- SUPPORT_LUI, 1, 1 enables LUI decode; 0 treats 0110111 as illegal.
- STATE_W, 4, width of state_o debug output (must be >=4).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  7  instr[6:0] from instruction register (valid from DECODE onward).
- zero  in  1  ALU zero flag (beq compare).
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe (valid with mem_req).
- adr_src  out  1  0=PC, 1=ALUOut as memory address.
- ir_write  out  1  load IR and OldPC.
- pc_write  out  1  load PC from result bus.
- reg_write  out  1  regfile write enable.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1.
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4.
- alu_op  out  2  00=add, 01=sub (branch), 10=funct-decoded.
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result direct, 11=imm (LUI).
- illegal  out  1  one-cycle pulse on unsupported opcode.
- state_o  out  STATE_W  current state encoding.

Behaviour:
- States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11.
- Reset (rst_n low, async): state=FETCH; all outputs 0 except mem_req=1 when state=FETCH after release (Moore from FETCH); illegal=0.
- Unlisted outputs default 0 in every state.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. Stays while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1 same cycle (Mealy on mem_ready), next=DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into ALUOut). Next by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL (if SUPPORT_JAL); 0110111 -> LUI (if SUPPORT_LUI); else illegal=1 this cycle, next=FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next MEMRD if opcode[5]=0 else MEMWR.
- MEMRD: mem_req=1, adr_src=1; hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1; next FETCH.
- MEMWR: mem_req=1, mem_we=1, adr_src=1; hold until mem_ready, then FETCH. mem_we never asserted outside MEMWR.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; next ALUWB. EXECI: same with alu_src_b=01; next ALUWB.
- ALUWB: result_src=00, reg_write=1; next FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (target from ALUOut); next ALUWB (writes OldPC+4 to rd).
- LUI: result_src=11, reg_write=1; next FETCH.
- Request held stable (mem_req, mem_we, adr_src unchanged) while mem_ready=0; no timeout.
- mem_ready ignored in non-memory states.
- Reset mid-instruction: immediate return to FETCH, no partial writes after rst_n falls.
- Latency (mem_ready=1 same cycle): R/I/LUI 4/4/3 cycles incl. fetch, lw 5, sw 4, beq 3, jal 4.

Test Plan:
- Reset then opcode=0110011, mem_ready=1 -> state seq 0,1,6,8,0; reg_write=1 only in state 8; alu_op=10 in 6.
- lw (0000011), mem_ready low 3 cycles in MEMRD -> state 3 held 4 cycles, mem_req=1/adr_src=1 stable, then 4 with result_src=01, reg_write=1.
- sw (0100011) -> seq 0,1,2,5,0; mem_we=1 only in 5; reg_write never 1.
- beq with zero=1 then zero=0 -> pc_write=1 in state 9 first run, 0 second run.
- opcode=1101111 with SUPPORT_JAL=0 -> illegal pulses 1 cycle in DECODE, next state 0, no write enables; with SUPPORT_JAL=1 -> seq 0,1,10,8,0.
- rst_n asserted while in MEMWR stalled -> state_o=0 asynchronously, mem_we=0 immediately.
